key_event_filter: RTL and testbench

Debounce-and-event stage between the 4x4 keypad scanner and the whack-a-mole game logic. It takes the scanner's 8 raw per-key levels and synchronises and debounces each one. It turns every debounced press into a single event (key index) and delivers events one at a time to the game logic over a valid/ready handshake. Presses that arrive while the consumer is busy are buffered per key; a repeat press on a key whose previous event is still unconsumed is dropped and flagged.

---
 rtl/key_event_filter.sv | 113 +++++++++++
 tb/tb_key_event_filter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_filter.sv
// Keypad debounce and press-event stage: synchronises and debounces each key line, then
// queues one pending event per key and presents events one at a time on a valid/ready slot.
module key_event_filter #(
    parameter int N_KEYS    = 8,
    parameter int DB_CYCLES = 250000,
    parameter int CNT_W     = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_level,
    input  logic              evt_ready,
    input  logic              clr_ovf,
    output logic              evt_valid,
    output logic [2:0]        evt_code,
    output logic [N_KEYS-1:0] key_stable,
    output logic              ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] stable_d;
    logic [N_KEYS-1:0] pend;
    logic [CNT_W-1:0]  cnt [N_KEYS];

    logic [N_KEYS-1:0] rise;
    logic [N_KEYS-1:0] sel_mask;
    logic [N_KEYS-1:0] load_mask;
    logic [N_KEYS-1:0] drop;
    logic [N_KEYS-1:0] pend_next;
    logic [2:0]        sel_code;
    logic              found;
    logic              slot_free;
    logic              load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_level;
            sync2 <= sync1;
        end
    end

    // Any cycle where the synchronised level matches the accepted one restarts qualification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_stable <= '0;
            for (int unsigned i = 0; i < N_KEYS; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                if (sync2[i] == key_stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] < CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else begin
                    key_stable[i] <= sync2[i];
                    cnt[i]        <= '0;
                end
            end
        end
    end

    always_comb begin
        sel_code = '0;
        sel_mask = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (pend[i] && !found) begin
                found       = 1'b1;
                sel_code    = 3'(i);
                sel_mask[i] = 1'b1;
            end
        end
    end

    // A key being moved into the slot this edge frees its pend bit, so a coincident edge is not a drop.
    always_comb begin
        rise      = key_stable & ~stable_d;
        slot_free = !evt_valid || evt_ready;
        load      = slot_free && (pend != '0);
        load_mask = load ? sel_mask : '0;
        drop      = rise & pend & ~load_mask;
        pend_next = (pend & ~load_mask) | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d  <= '0;
            pend      <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            ovf       <= 1'b0;
        end else begin
            stable_d <= key_stable;
            pend     <= pend_next;
            if (load) begin
                evt_valid <= 1'b1;
                evt_code  <= sel_code;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (drop != '0) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_event_filter.sv
// Scoreboard bench for key_event_filter: expected codes are queued as presses are driven
// and checked as the DUT hands events over.
module tb_key_event_filter;

    localparam int N_KEYS = 8;
    localparam int DB     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_KEYS-1:0] key_level = '0;
    logic              evt_ready = 1'b0;
    logic              clr_ovf = 1'b0;
    logic              evt_valid;
    logic [2:0]        evt_code;
    logic [N_KEYS-1:0] key_stable;
    logic              ovf;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    key_event_filter #(.N_KEYS(N_KEYS), .DB_CYCLES(DB), .CNT_W(18)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_level  (key_level),
        .evt_ready  (evt_ready),
        .clr_ovf    (clr_ovf),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .key_stable (key_stable),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check(tag, exp_q.size(), 0);
    endtask

    // Transfer happens on the next rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            check("evt_expected", {31'd0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) check("evt_code", {29'd0, evt_code}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] bounce;
        tick(3);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_stable", key_stable, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick(2);

        // Clean press of key 2
        key_level = 8'h04;
        evt_ready = 1'b1;
        exp_q.push_back(2);
        tick(5);
        check("clean_stable_e4", key_stable, 8'h00);
        tick(1);
        check("clean_stable_e5", key_stable, 8'h04);
        tick(1);
        check("clean_valid_e6", evt_valid, 0);
        tick(1);
        check("clean_valid_e7", evt_valid, 1);
        check("clean_code_e7", evt_code, 2);
        tick(1);
        check("clean_valid_e8", evt_valid, 0);
        check("clean_ovf", ovf, 0);
        key_level = 8'h00;
        tick(10);
        check("release_stable", key_stable, 8'h00);
        check("release_no_evt", evt_valid, 0);

        // Glitch shorter than qualification, then a bouncing press
        key_level = 8'h20;
        tick(3);
        key_level = 8'h00;
        tick(10);
        check("glitch_stable", key_stable, 8'h00);
        bounce = 7'b1111011;
        exp_q.push_back(5);
        for (int i = 0; i < 7; i++) begin
            key_level[5] = bounce[i];
            tick(1);
        end
        tick(10);
        check("bounce_stable", key_stable, 8'h20);
        wait_drain("bounce_drain", 10);
        key_level = 8'h00;
        tick(10);

        // Simultaneous presses under backpressure
        evt_ready = 1'b0;
        key_level = 8'h4A;
        exp_q.push_back(1);
        exp_q.push_back(3);
        exp_q.push_back(6);
        tick(10);
        check("bp_valid_a", evt_valid, 1);
        check("bp_code_a", evt_code, 1);
        tick(4);
        check("bp_valid_b", evt_valid, 1);
        check("bp_code_b", evt_code, 1);
        evt_ready = 1'b1;
        tick(1);
        check("bp_code_2nd", evt_code, 3);
        tick(1);
        check("bp_code_3rd", evt_code, 6);
        tick(1);
        check("bp_valid_end", evt_valid, 0);
        check("bp_drain", exp_q.size(), 0);
        key_level = 8'h00;
        tick(10);

        // Overflow on key 0
        evt_ready = 1'b0;
        key_level = 8'h01;
        exp_q.push_back(0);
        exp_q.push_back(0);
        tick(10);
        check("ovf_slot_valid", evt_valid, 1);
        check("ovf_slot_code", evt_code, 0);
        key_level = 8'h00;
        tick(10);
        key_level = 8'h01;
        tick(10);
        check("ovf_second_press", ovf, 0);
        key_level = 8'h00;
        tick(10);
        key_level = 8'h01;
        tick(10);
        check("ovf_third_press", ovf, 1);
        evt_ready = 1'b1;
        wait_drain("ovf_drain", 10);
        tick(2);
        check("ovf_drained_valid", evt_valid, 0);
        check("ovf_sticky", ovf, 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("ovf_cleared", ovf, 0);
        key_level = 8'h00;
        tick(10);

        // Asynchronous reset with an event presented and key 4 mid-qualification
        evt_ready = 1'b0;
        key_level = 8'h80;
        exp_q.push_back(7);
        tick(10);
        check("mid_valid", evt_valid, 1);
        check("mid_code", evt_code, 7);
        key_level = 8'h90;
        tick(3);
        exp_q.delete();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", evt_valid, 0);
        check("arst_code", evt_code, 0);
        check("arst_stable", key_stable, 8'h00);
        check("arst_ovf", ovf, 0);
        #2 rst = 1'b0;
        evt_ready = 1'b1;
        exp_q.push_back(4);
        exp_q.push_back(7);
        tick(6);
        check("requal_early", evt_valid, 0);
        wait_drain("requal_drain", 20);
        tick(1);
        check("requal_idle", evt_valid, 0);
        check("requal_stable", key_stable, 8'h90);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
